// File: rtl/dmem_responder.sv
// Word-organised data memory behind a request/response handshake with programmable wait states.
// Optional alignment check enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [3:0]  req_wmask,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  dbg_state
);
    // Handshake: a request transfers on a rising edge with req_valid & req_ready high,
    // a response on a rising edge with resp_valid & resp_ready high; each side holds
    // its payload stable while its valid is high and the transfer has not happened.
    localparam int DEPTH = 1 << (ADDR_WIDTH - 2);
    localparam logic [3:0] COUNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    logic [3:0]              count;
    logic [ADDR_WIDTH-3:0]   word_q;
    logic [1:0]              off_q;
    logic                    we_q;
    logic [3:0]              wmask_q;
    logic [31:0]             wdata_q;
    logic [31:0]             mem [DEPTH];

    logic [ADDR_WIDTH-3:0]   acc_word;
    logic [1:0]              acc_off;
    logic                    acc_we;
    logic [3:0]              acc_mask;
    logic [31:0]             acc_data;
    logic                    acc_ok;
    logic                    do_access;
    logic                    unused_bits;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign dbg_state  = state;

    // With zero wait states the access uses the request as it is being accepted.
    always_comb begin
        acc_word = word_q;
        acc_off  = off_q;
        acc_we   = we_q;
        acc_mask = wmask_q;
        acc_data = wdata_q;
        if (state == IDLE) begin
            acc_word = req_addr[ADDR_WIDTH-1:2];
            acc_off  = req_addr[1:0];
            acc_we   = req_we;
            acc_mask = req_wmask;
            acc_data = req_wdata;
        end
    end

    assign do_access = ((state == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                       ((state == WAIT) && (count == 4'd0));

`ifdef DMEM_ALIGN_CHECK_EN
    function automatic logic align_ok(input logic [3:0] m, input logic [1:0] o);
        case ({m, o})
            6'b0001_00, 6'b0010_01, 6'b0100_10, 6'b1000_11,
            6'b0011_00, 6'b1100_10, 6'b1111_00: align_ok = 1'b1;
            default:                            align_ok = 1'b0;
        endcase
    endfunction

    assign acc_ok      = align_ok(acc_mask, acc_off);
    assign unused_bits = ^req_addr[31:ADDR_WIDTH];
`else
    assign acc_ok      = 1'b1;
    assign unused_bits = ^{req_addr[31:ADDR_WIDTH], acc_off};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= 4'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            word_q     <= '0;
            off_q      <= 2'd0;
            we_q       <= 1'b0;
            wmask_q    <= 4'd0;
            wdata_q    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        word_q  <= req_addr[ADDR_WIDTH-1:2];
                        off_q   <= req_addr[1:0];
                        we_q    <= req_we;
                        wmask_q <= req_wmask;
                        wdata_q <= req_wdata;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            count <= COUNT_LOAD;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (count == 4'd0) begin
                        state <= RESP;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Read returns the pre-write word; a rejected access neither reads nor writes.
            if (do_access) begin
                resp_rdata <= acc_ok ? mem[acc_word] : 32'd0;
                resp_err   <= ~acc_ok;
                if (acc_we && acc_ok) begin
                    for (int i = 0; i < 4; i++) begin
                        if (acc_mask[i]) begin
                            mem[acc_word][8*i +: 8] <= acc_data[8*i +: 8];
                        end
                    end
                end
            end
        end
    end
endmodule
